// File: rtl/sweep_pkg.sv
// Shared definitions for the sweep stimulus generator.
// Contents:
//    mode_e  - sweep mode encodings; these match the 2-bit mode input.
//    state_e - sequencer states.
//    clog2   - ceiling log2, used to size the dwell counter.
package sweep_pkg;

   typedef enum logic [1:0] {
      MODE_DOWN     = 2'b00,
      MODE_UP       = 2'b01,
      MODE_PINGPONG = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_e;

   // Returns the number of bits needed to hold the values 0..value-1.
   // A counter that must reach PERIOD therefore uses clog2(PERIOD+1) bits.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((64'(1) << result) < 64'(value)) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sweep_stim_gen_if.sv
// Control and pattern bus of the sweep stimulus generator.
// Signals:
//    start    - single-cycle start request
//    stop     - single-cycle abort request (wins over start)
//    mode     - sweep mode, sampled on an accepted start
//    cont     - 1 = repeat forever, 0 = single shot; sampled on an accepted start
//    ch_en    - live per-channel enable
//    pat      - replicated pattern; channel k is pat[k*W +: W]
//    step_stb - one-cycle pulse on every newly loaded value
//    busy     - high while sweeping
//    done     - sticky completion flag
// The master modport is used by whoever drives the requests; the generator
// itself connects through the slave modport.
interface sweep_stim_gen_if #(
   parameter int W  = 4,
   parameter int CH = 3
);
   logic            start;
   logic            stop;
   logic [1:0]      mode;
   logic            cont;
   logic [CH-1:0]   ch_en;
   logic [W*CH-1:0] pat;
   logic            step_stb;
   logic            busy;
   logic            done;

   modport master (
      output start, stop, mode, cont, ch_en,
      input  pat, step_stb, busy, done
   );

   modport slave (
      input  start, stop, mode, cont, ch_en,
      output pat, step_stb, busy, done
   );
endinterface

// File: rtl/sweep_tick_div.sv
// Dwell counter for the sweep generator.
// Ports:
//    clk  - system clock
//    rst  - asynchronous active-high reset
//    clr  - synchronous clear back to 0
//    en   - count enable
//    tick - high while the count equals PERIOD-1 (last cycle of a dwell)
module sweep_tick_div
   import sweep_pkg::*;
#(
   parameter int PERIOD = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = clog2(PERIOD + 1);
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] count_q;

   assign tick = (count_q == LAST);

   // The counter wraps to 0 on the same edge that the sequencer consumes the
   // tick, so each value dwells for exactly PERIOD cycles. With PERIOD=1 the
   // count stays at 0 and tick is permanently high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         if (tick) begin
            count_q <= '0;
         end else begin
            count_q <= count_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sweep_stim_gen.sv
// On-board stimulus sequencer: steps a W-bit value through a down, up,
// ping-pong or hold-max sweep, holding each value PERIOD cycles, and drives
// it replicated onto CH channel slices masked by a live channel enable.
// Ports:
//    clk - system clock
//    rst - asynchronous active-high reset (aborts without completion)
//    bus - sweep_stim_gen_if slave modport (requests in, pattern/status out)
module sweep_stim_gen
   import sweep_pkg::*;
#(
   parameter int W      = 4,
   parameter int CH     = 3,
   parameter int PERIOD = 20
) (
   input logic               clk,
   input logic               rst,
   sweep_stim_gen_if.slave   bus
);

   localparam logic [W-1:0] MAX_VAL = '1;
   localparam logic [W-1:0] ONE     = W'(1);

   state_e       state_q, state_d;
   mode_e        mode_q, mode_d;
   logic         cont_q, cont_d;
   logic         dir_down_q, dir_down_d;
   logic [W-1:0] value_q, value_d;
   logic         done_q, done_d;
   logic         stb_q, stb_d;
   logic         tick;
   logic         div_clr;
   logic         seq_last;
   logic [W-1:0] next_value;
   logic         next_dir_down;
   logic [W*CH-1:0] pat_masked;

   function automatic logic [W-1:0] start_value(input mode_e m);
      return (m == MODE_UP || m == MODE_PINGPONG) ? '0 : MAX_VAL;
   endfunction

   sweep_tick_div #(
      .PERIOD (PERIOD)
   ) u_tick_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (div_clr),
      .en   (state_q == RUN),
      .tick (tick)
   );

   // Decide whether the current value is the final one of its sequence and
   // what the following value would be. Ping-pong turns around at the peak
   // without repeating it, and finishes when it is back at 0 going down.
   always_comb begin
      seq_last      = 1'b0;
      next_value    = value_q;
      next_dir_down = dir_down_q;
      unique case (mode_q)
         MODE_DOWN: begin
            seq_last   = (value_q == '0);
            next_value = value_q - ONE;
         end
         MODE_UP: begin
            seq_last   = (value_q == MAX_VAL);
            next_value = value_q + ONE;
         end
         MODE_PINGPONG: begin
            seq_last = dir_down_q && (value_q == '0);
            if (dir_down_q) begin
               next_value = value_q - ONE;
            end else if (value_q == MAX_VAL) begin
               next_value    = value_q - ONE;
               next_dir_down = 1'b1;
            end else begin
               next_value = value_q + ONE;
            end
         end
         default: begin
            seq_last = 1'b1;
         end
      endcase
   end

   // Sequencer next-state logic. Stop overrides everything, a start is only
   // accepted from IDLE or FIN, and at the end of a continuous sequence the
   // start value reloads on the very next edge so there is no dead cycle.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      cont_d     = cont_q;
      dir_down_d = dir_down_q;
      value_d    = value_q;
      done_d     = done_q;
      stb_d      = 1'b0;
      div_clr    = 1'b0;
      if (bus.stop) begin
         state_d    = IDLE;
         value_d    = '0;
         done_d     = 1'b0;
         dir_down_d = 1'b0;
         div_clr    = 1'b1;
      end else begin
         unique case (state_q)
            IDLE, FIN: begin
               if (bus.start) begin
                  mode_d     = mode_e'(bus.mode);
                  cont_d     = bus.cont;
                  value_d    = start_value(mode_e'(bus.mode));
                  dir_down_d = 1'b0;
                  done_d     = 1'b0;
                  stb_d      = 1'b1;
                  div_clr    = 1'b1;
                  state_d    = RUN;
               end
            end
            RUN: begin
               if (tick) begin
                  if (!seq_last) begin
                     value_d    = next_value;
                     dir_down_d = next_dir_down;
                     stb_d      = 1'b1;
                  end else if (cont_q) begin
                     value_d    = start_value(mode_q);
                     dir_down_d = 1'b0;
                     stb_d      = 1'b1;
                  end else begin
                     state_d = FIN;
                     done_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Sequencer registers; reset drops straight back to an idle, incomplete state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= MODE_DOWN;
         cont_q     <= 1'b0;
         dir_down_q <= 1'b0;
         value_q    <= '0;
         done_q     <= 1'b0;
         stb_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         cont_q     <= cont_d;
         dir_down_q <= dir_down_d;
         value_q    <= value_d;
         done_q     <= done_d;
         stb_q      <= stb_d;
      end
   end

   // Channel masking is purely combinational so an enable change shows up
   // on the pattern in the same cycle.
   always_comb begin
      pat_masked = '0;
      for (int k = 0; k < CH; k++) begin
         pat_masked[k*W +: W] = bus.ch_en[k] ? value_q : '0;
      end
   end

   assign bus.pat      = pat_masked;
   assign bus.step_stb = stb_q;
   assign bus.busy     = (state_q == RUN);
   assign bus.done     = done_q;

endmodule

// File: tb/tb_sweep_stim_gen.sv
// Self-checking bench for sweep_stim_gen. Two instances share clock and
// reset: dut_a with PERIOD=20 and dut_b with PERIOD=1. Expected patterns
// come from a value list built straight from the sweep rules.
module tb_sweep_stim_gen;

   localparam int W    = 4;
   localparam int CH   = 3;
   localparam int MAXV = (1 << W) - 1;
   localparam logic [1:0] M_DOWN = 2'b00;
   localparam logic [1:0] M_UP   = 2'b01;
   localparam logic [1:0] M_PP   = 2'b10;
   localparam logic [1:0] M_HOLD = 2'b11;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   exp_seq[$];

   always #5 clk = ~clk;

   sweep_stim_gen_if #(.W(W), .CH(CH)) ifa ();
   sweep_stim_gen_if #(.W(W), .CH(CH)) ifb ();

   sweep_stim_gen #(.W(W), .CH(CH), .PERIOD(20)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   sweep_stim_gen #(.W(W), .CH(CH), .PERIOD(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   // Value list of one full sequence for a mode.
   function automatic void build_seq(input logic [1:0] m);
      exp_seq.delete();
      case (m)
         M_DOWN: for (int v = MAXV; v >= 0; v--) exp_seq.push_back(v);
         M_UP:   for (int v = 0; v <= MAXV; v++) exp_seq.push_back(v);
         M_PP: begin
            for (int v = 0; v <= MAXV; v++) exp_seq.push_back(v);
            for (int v = MAXV - 1; v >= 0; v--) exp_seq.push_back(v);
         end
         default: exp_seq.push_back(MAXV);
      endcase
   endfunction

   function automatic logic [W*CH-1:0] replicate(input int v, input logic [CH-1:0] en);
      logic [W*CH-1:0] r;
      r = '0;
      for (int k = 0; k < CH; k++) begin
         if (en[k]) r[k*W +: W] = v[W-1:0];
      end
      return r;
   endfunction

   function automatic logic [W*CH-1:0] get_pat(input int sel);
      return (sel == 0) ? ifa.pat : ifb.pat;
   endfunction
   function automatic logic get_stb(input int sel);
      return (sel == 0) ? ifa.step_stb : ifb.step_stb;
   endfunction
   function automatic logic get_busy(input int sel);
      return (sel == 0) ? ifa.busy : ifb.busy;
   endfunction
   function automatic logic get_done(input int sel);
      return (sel == 0) ? ifa.done : ifb.done;
   endfunction

   task automatic set_in(input int sel, input logic st, input logic sp,
                         input logic [1:0] m, input logic c);
      if (sel == 0) begin
         ifa.start = st; ifa.stop = sp; ifa.mode = m; ifa.cont = c;
      end else begin
         ifb.start = st; ifb.stop = sp; ifb.mode = m; ifb.cont = c;
      end
   endtask

   task automatic set_en(input int sel, input logic [CH-1:0] en);
      if (sel == 0) ifa.ch_en = en;
      else ifb.ch_en = en;
   endtask

   task automatic advance(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called just after an edge; leaves the bench just after the accepting edge.
   task automatic pulse_start(input int sel, input logic [1:0] m, input logic c,
                              input logic with_stop);
      set_in(sel, 1'b1, with_stop, m, c);
      advance(1);
      set_in(sel, 1'b0, 1'b0, m, c);
   endtask

   task automatic do_stop(input int sel);
      set_in(sel, 1'b0, 1'b1, 2'b00, 1'b0);
      advance(1);
      set_in(sel, 1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(0, 1'b0, 1'b0, 2'b00, 1'b0);
      set_in(1, 1'b0, 1'b0, 2'b00, 1'b0);
      set_en(0, 3'b111);
      set_en(1, 3'b111);
      advance(2);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (get_pat(s) !== '0) begin
            failures++; $display("[TB] FAIL reset_pat sel=%0d got=%h exp=000", s, get_pat(s));
         end
         checks++;
         if (get_busy(s) !== 1'b0 || get_done(s) !== 1'b0 || get_stb(s) !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags sel=%0d got busy=%b done=%b stb=%b exp 0/0/0",
                     s, get_busy(s), get_done(s), get_stb(s));
         end
      end
      rst = 1'b0;
      advance(2);
      checks++;
      if (ifa.busy !== 1'b0 || ifa.pat !== '0) begin
         failures++; $display("[TB] FAIL reset_idle got busy=%b pat=%h exp 0/000", ifa.busy, ifa.pat);
      end
   endtask

   // Single-shot sweep with a random channel enable, checked every cycle.
   task automatic test_sweep(input int sel, input logic [1:0] m);
      int            period;
      int            stb_count;
      int            cyc;
      int            last;
      logic [CH-1:0] en;
      logic [W*CH-1:0] exp_pat;
      period = (sel == 0) ? 20 : 1;
      en = CH'($urandom_range(1, (1 << CH) - 1));
      set_en(sel, en);
      build_seq(m);
      pulse_start(sel, m, 1'b0, 1'b0);
      stb_count = 0;
      cyc = 0;
      foreach (exp_seq[i]) begin
         for (int c = 0; c < period; c++) begin
            exp_pat = replicate(exp_seq[i], en);
            checks++;
            if (get_pat(sel) !== exp_pat) begin
               failures++;
               $display("[TB] FAIL sweep_pat sel=%0d mode=%0d cycle=%0d got=%h exp=%h",
                        sel, m, cyc, get_pat(sel), exp_pat);
            end
            checks++;
            if (get_stb(sel) !== (c == 0)) begin
               failures++;
               $display("[TB] FAIL sweep_stb sel=%0d mode=%0d cycle=%0d got=%b exp=%b",
                        sel, m, cyc, get_stb(sel), (c == 0));
            end
            checks++;
            if (get_busy(sel) !== 1'b1 || get_done(sel) !== 1'b0) begin
               failures++;
               $display("[TB] FAIL sweep_status sel=%0d mode=%0d cycle=%0d got busy=%b done=%b exp 1/0",
                        sel, m, cyc, get_busy(sel), get_done(sel));
            end
            if (get_stb(sel) === 1'b1) stb_count++;
            cyc++;
            advance(1);
         end
      end
      last = exp_seq[exp_seq.size() - 1];
      checks++;
      if (get_busy(sel) !== 1'b0 || get_done(sel) !== 1'b1 || get_stb(sel) !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sweep_end sel=%0d mode=%0d got busy=%b done=%b stb=%b exp 0/1/0",
                  sel, m, get_busy(sel), get_done(sel), get_stb(sel));
      end
      checks++;
      if (get_pat(sel) !== replicate(last, en)) begin
         failures++;
         $display("[TB] FAIL sweep_end_pat sel=%0d got=%h exp=%h", sel, get_pat(sel), replicate(last, en));
      end
      checks++;
      if (stb_count != exp_seq.size()) begin
         failures++;
         $display("[TB] FAIL sweep_stb_count sel=%0d mode=%0d got=%0d exp=%0d",
                  sel, m, stb_count, exp_seq.size());
      end
   endtask

   task automatic test_cont_wrap();
      set_en(0, 3'b111);
      build_seq(M_UP);
      pulse_start(0, M_UP, 1'b1, 1'b0);
      for (int r = 0; r < 3; r++) begin
         foreach (exp_seq[i]) begin
            for (int c = 0; c < 20; c++) begin
               checks++;
               if (ifa.pat !== replicate(exp_seq[i], 3'b111) || ifa.step_stb !== (c == 0)) begin
                  failures++;
                  $display("[TB] FAIL cont_pat wrap=%0d idx=%0d c=%0d got pat=%h stb=%b exp pat=%h stb=%b",
                           r, i, c, ifa.pat, ifa.step_stb, replicate(exp_seq[i], 3'b111), (c == 0));
               end
               checks++;
               if (ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
                  failures++;
                  $display("[TB] FAIL cont_status wrap=%0d idx=%0d got busy=%b done=%b exp 1/0",
                           r, i, ifa.busy, ifa.done);
               end
               advance(1);
            end
         end
      end
      checks++;
      if (ifa.pat !== 12'h000 || ifa.step_stb !== 1'b1 || ifa.busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL cont_fourth got pat=%h stb=%b busy=%b exp 000/1/1",
                  ifa.pat, ifa.step_stb, ifa.busy);
      end
      do_stop(0);
   endtask

   task automatic test_ch_en();
      logic [CH-1:0] en;
      set_en(0, 3'b111);
      pulse_start(0, M_UP, 1'b0, 1'b0);
      advance(125);
      set_en(0, 3'b101);
      #1;
      checks++;
      if (ifa.pat !== 12'h606) begin
         failures++; $display("[TB] FAIL ch_en_mask got=%h exp=606", ifa.pat);
      end
      set_en(0, 3'b111);
      #1;
      checks++;
      if (ifa.pat !== 12'h666) begin
         failures++; $display("[TB] FAIL ch_en_restore got=%h exp=666", ifa.pat);
      end
      en = CH'($urandom_range(0, (1 << CH) - 1));
      set_en(0, en);
      #1;
      checks++;
      if (ifa.pat !== replicate(6, en)) begin
         failures++; $display("[TB] FAIL ch_en_random en=%b got=%h exp=%h", en, ifa.pat, replicate(6, en));
      end
      set_en(0, 3'b111);
      do_stop(0);
   endtask

   task automatic test_stop();
      do_stop(1);
      checks++;
      if (ifb.done !== 1'b0 || ifb.busy !== 1'b0 || ifb.pat !== '0) begin
         failures++;
         $display("[TB] FAIL stop_from_fin got done=%b busy=%b pat=%h exp 0/0/000", ifb.done, ifb.busy, ifb.pat);
      end
      set_en(0, 3'b111);
      pulse_start(0, M_DOWN, 1'b0, 1'b0);
      advance(43);
      pulse_start(0, M_UP, 1'b0, 1'b0);
      checks++;
      if (ifa.pat !== 12'hDDD || ifa.step_stb !== 1'b0) begin
         failures++;
         $display("[TB] FAIL start_in_run got pat=%h stb=%b exp DDD/0", ifa.pat, ifa.step_stb);
      end
      advance(56);
      checks++;
      if (ifa.pat !== 12'hAAA || ifa.step_stb !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stop_setup got pat=%h stb=%b exp AAA/1", ifa.pat, ifa.step_stb);
      end
      pulse_start(0, M_UP, 1'b0, 1'b1);
      checks++;
      if (ifa.pat !== 12'h000 || ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.step_stb !== 1'b0) begin
         failures++;
         $display("[TB] FAIL stop_priority got pat=%h busy=%b done=%b stb=%b exp 000/0/0/0",
                  ifa.pat, ifa.busy, ifa.done, ifa.step_stb);
      end
      advance(3);
      checks++;
      if (ifa.pat !== 12'h000 || ifa.busy !== 1'b0) begin
         failures++; $display("[TB] FAIL stop_stays_idle got pat=%h busy=%b exp 000/0", ifa.pat, ifa.busy);
      end
   endtask

   task automatic test_async_reset();
      set_en(0, 3'b111);
      pulse_start(0, M_DOWN, 1'b0, 1'b0);
      advance(125);
      checks++;
      if (ifa.pat !== 12'h999) begin
         failures++; $display("[TB] FAIL rst_setup got=%h exp=999", ifa.pat);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (ifa.pat !== 12'h000 || ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.step_stb !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_async got pat=%h busy=%b done=%b stb=%b exp 000/0/0/0",
                  ifa.pat, ifa.busy, ifa.done, ifa.step_stb);
      end
      #3;
      rst = 1'b0;
      advance(1);
      checks++;
      if (ifa.pat !== 12'h000 || ifa.done !== 1'b0 || ifa.busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_release got pat=%h done=%b busy=%b exp 000/0/0", ifa.pat, ifa.done, ifa.busy);
      end
      pulse_start(0, M_DOWN, 1'b0, 1'b0);
      checks++;
      if (ifa.pat !== 12'hFFF || ifa.step_stb !== 1'b1 || ifa.busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rst_restart got pat=%h stb=%b busy=%b exp FFF/1/1", ifa.pat, ifa.step_stb, ifa.busy);
      end
      advance(20);
      checks++;
      if (ifa.pat !== 12'hEEE || ifa.step_stb !== 1'b1) begin
         failures++; $display("[TB] FAIL rst_second got pat=%h stb=%b exp EEE/1", ifa.pat, ifa.step_stb);
      end
      do_stop(0);
   endtask

   initial begin
      test_reset();
      test_sweep(0, M_DOWN);
      test_sweep(1, M_PP);
      test_cont_wrap();
      test_ch_en();
      test_stop();
      test_async_reset();
      test_sweep(1, M_HOLD);
      for (int n = 0; n < 5; n++) begin
         test_sweep(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
